led_control: RTL and testbench



---
 rtl/led_control_pkg.sv | 14 +
 rtl/led_blinker.sv | 42 ++++
 rtl/led_control.sv | 31 +++
 tb/tb_led_control.sv | 127 ++++++++++++
 4 files changed

// File: rtl/led_control_pkg.sv
// Shared constants and helpers for the LED control block.
// Counter sizing lives here so top and blinker agree on widths.
package led_control_pkg;

  localparam int DEFAULT_TOGGLE_CYCLES = 10_000_000;

  // Bits needed to hold 0..cycles, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_blinker.sv
// Free-running cycle counter that inverts blink every TOGGLE_CYCLES edges.
// Synchronous active-high reset clears both the count and the output.
module led_blinker
  import led_control_pkg::*;
#(
  parameter int TOGGLE_CYCLES = DEFAULT_TOGGLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic blink
);

  localparam int W = cnt_width(TOGGLE_CYCLES);
  localparam logic [W-1:0] LAST = W'(TOGGLE_CYCLES - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q + ONE;
    blink_d = blink_q;
    if (cnt_q == LAST) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end
  end

  // Reset wins over a wrap landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/led_control.sv
// Switch-to-LED glue plus an optional blinker on led[2].
// Blinker is built only when LED_CONTROL_BLINK_EN is defined.
module led_control
  import led_control_pkg::*;
#(
  parameter int TOGGLE_CYCLES = DEFAULT_TOGGLE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s,
  output logic [2:0] led
);

  assign led[0] = s[1] ^ s[0];
  assign led[1] = s[3] & s[2];

`ifdef LED_CONTROL_BLINK_EN
  led_blinker #(
    .TOGGLE_CYCLES (TOGGLE_CYCLES)
  ) u_blinker (
    .clk   (clk),
    .reset (reset),
    .blink (led[2])
  );
`else
  logic unused_blink;
  assign unused_blink = clk ^ reset ^ (TOGGLE_CYCLES == 0);
  assign led[2] = 1'b0;
`endif

endmodule

// File: tb/tb_led_control.sv
// Directed bench for led_control plus standalone led_blinker instances.
// Expected blink levels are queued per edge and popped after it.
module tb_led_control;

  logic       clk;
  logic       reset;
  logic [3:0] s;
  logic [2:0] led;
  logic       blink4;
  logic       blink1;

  int total = 0;
  int bad   = 0;
  int k4    = 0;
  int k1    = 0;

  typedef struct packed {
    logic top;
    logic b4;
    logic b1;
  } exp_t;

  exp_t sb[$];

  led_control #(.TOGGLE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .led   (led)
  );

  led_blinker #(.TOGGLE_CYCLES(4)) u_b4 (
    .clk   (clk),
    .reset (reset),
    .blink (blink4)
  );

  led_blinker #(.TOGGLE_CYCLES(1)) u_b1 (
    .clk   (clk),
    .reset (reset),
    .blink (blink1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [1:0] obs,
                     input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_sw();
    logic [1:0] e;
    e = {s[3] & s[2], s[1] ^ s[0]};
    chk("led10", led[1:0], e);
  endtask

  // One clock edge: queue the expected blink levels, then compare.
  task automatic step(input logic rst);
    exp_t e;
    reset = rst;
    if (rst) begin
      k4 = 0;
      k1 = 0;
    end else begin
      k4++;
      k1++;
    end
    e.b4 = ((k4 / 4) % 2) == 1;
    e.b1 = (k1 % 2) == 1;
`ifdef LED_CONTROL_BLINK_EN
    e.top = e.b4;
`else
    e.top = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("led2", {1'b0, led[2]}, {1'b0, e.top});
    chk("blink4", {1'b0, blink4}, {1'b0, e.b4});
    chk("blink1", {1'b0, blink1}, {1'b0, e.b1});
    s = 4'($urandom_range(0, 15));
    #1;
    chk_sw();
  endtask

  initial begin
    logic [3:0] v;
    reset = 1'b1;
    s     = 4'b0000;

    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      s = v;
      #1;
      chk("sweep", led[1:0], {v[3] & v[2], v[1] ^ v[0]});
    end
    s = 4'b1101;
    #1;
    chk("s1101", led[1:0], 2'b11);
    s = 4'b0110;
    #1;
    chk("s0110", led[1:0], 2'b01);

    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 12; i++) step(1'b0);

    step(1'b1);
    for (int i = 0; i < 6; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 23; i++) step(1'b0);

    step(1'b1);
    for (int i = 0; i < 80; i++) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
